text_overlay_engine: RTL and testbench

- Parametrised character-cell text overlay for the VGA path. It replaces per-character text instances with a ROWS x COLS character buffer, written over a valid/ready port.
- Each cell holds a 7-bit ASCII code plus a 2-bit attribute (colour select, blink).
- The block scans the buffer against the incoming pixel x/y, drives the external 8x16 ascii_rom, and outputs registered 12-bit RGB with delay-matched sync signals.

---
 rtl/text_overlay_pkg.sv | 20 ++
 rtl/char_buffer_ram.sv | 26 ++
 rtl/text_overlay_engine.sv | 181 ++++++++++++++++++
 tb/tb_text_overlay_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_overlay_pkg.sv
// rtl/text_overlay_pkg.sv - shared constants and types for the text overlay engine
package text_overlay_pkg;
  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int ASCII_W    = 7;
  localparam int ATTR_W     = 2;
  localparam int CELL_W     = ASCII_W + ATTR_W;
  localparam logic [ASCII_W-1:0] CHAR_SPACE = 7'h20;
  localparam int ATTR_FGSEL = 0;
  localparam int ATTR_BLINK = 1;
  localparam int PIPE_LAT   = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR
  } state_e;
endpackage

// File: rtl/char_buffer_ram.sv
// rtl/char_buffer_ram.sv - simple dual-port character cell RAM, synchronous read-first
module char_buffer_ram
  import text_overlay_pkg::*;
#(
  parameter int DEPTH = 320,
  parameter int AW    = 9,
  parameter int DW    = CELL_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Read samples the old contents when the same cell is written this edge.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/text_overlay_engine.sv
// rtl/text_overlay_engine.sv - character-cell text overlay with buffer clear FSM and 3-stage pixel pipe
module text_overlay_engine
  import text_overlay_pkg::*;
#(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 8,
  parameter int          ORIGIN_X   = 80,
  parameter int          ORIGIN_Y   = 80,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [11:0] FG0        = 12'hFFF,
  parameter logic [11:0] FG1        = 12'hF00,
  parameter logic [11:0] BG         = 12'h008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [11:0] rgb,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_row,
  input  logic [6:0]  wr_col,
  input  logic [6:0]  wr_char,
  input  logic [1:0]  wr_attr,
  output logic        wr_err,
  input  logic        clr_start,
  output logic        busy
);
  localparam int NCELL = ROWS * COLS;
  localparam int AW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int WIN_W = COLS * (GLYPH_W << SCALE_LOG2);
  localparam int WIN_H = ROWS * (GLYPH_H << SCALE_LOG2);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NCELL - 1);
  localparam logic [4:0]    ROWS_L    = 5'(ROWS);
  localparam logic [6:0]    COLS_L    = 7'(COLS);

  state_e            r_state;
  logic [AW-1:0]     r_clr_ptr;
  logic              r_wr_err;
  logic [4:0]        r_frame_cnt;

  logic              w_wr_fire;
  logic              w_wr_in_range;
  logic [AW-1:0]     w_wr_addr;
  logic              w_ram_we;
  logic [AW-1:0]     w_ram_waddr;
  logic [CELL_W-1:0] w_ram_wdata;
  logic [AW-1:0]     w_ram_raddr;
  logic [CELL_W-1:0] w_ram_rdata;

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic              w_in_win;
  logic              w_bit;
  logic              w_blink;
  logic              w_vs_fall;

  logic              r0_in_win, r0_video, r0_hs, r0_vs;
  logic [3:0]        r0_grow;
  logic [2:0]        r0_gcol;
  logic              r1_in_win, r1_video, r1_hs, r1_vs;
  logic [2:0]        r1_gcol;
  logic [ATTR_W-1:0] r1_attr;
  logic [11:0]       r_rgb;
  logic              r_hs_out, r_vs_out;

  assign busy          = (r_state == CLEAR);
  assign wr_ready      = (r_state == IDLE);
  assign wr_err        = r_wr_err;
  assign w_wr_fire     = wr_valid && wr_ready;
  assign w_wr_in_range = (wr_row < ROWS_L) && (wr_col < COLS_L);
  assign w_wr_addr     = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

  // The clear owns the write port; host writes only land while IDLE.
  assign w_ram_we    = busy || (w_wr_fire && w_wr_in_range);
  assign w_ram_waddr = busy ? r_clr_ptr : w_wr_addr;
  assign w_ram_wdata = busy ? {CHAR_SPACE, 2'b00} : {wr_char, wr_attr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_err <= w_wr_fire && !w_wr_in_range;
      if (r_state == CLEAR) begin
        if (r_clr_ptr == LAST_ADDR) begin
          r_state   <= IDLE;
          r_clr_ptr <= '0;
        end else begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
        end
      end else if (clr_start) begin
        r_state   <= CLEAR;
        r_clr_ptr <= '0;
      end
    end
  end

  assign w_dx     = {1'b0, x} - 11'(ORIGIN_X);
  assign w_dy     = {1'b0, y} - 11'(ORIGIN_Y);
  assign w_in_win = !w_dx[10] && !w_dy[10] &&
                    (32'(w_dx[9:0]) < WIN_W) && (32'(w_dy[9:0]) < WIN_H);
  assign w_ram_raddr = w_in_win ?
      (AW'(w_dy[9:0] >> (4 + SCALE_LOG2)) * AW'(COLS) + AW'(w_dx[9:0] >> (3 + SCALE_LOG2))) : '0;

  char_buffer_ram #(
    .DEPTH (NCELL),
    .AW    (AW),
    .DW    (CELL_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  assign rom_addr  = {w_ram_rdata[CELL_W-1:ATTR_W], r0_grow};
  assign w_bit     = rom_data[3'd7 - r1_gcol];
  assign w_blink   = r_frame_cnt[4];
  assign w_vs_fall = r1_vs && !r0_vs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0_in_win   <= 1'b0;
      r0_video    <= 1'b0;
      r0_hs       <= 1'b0;
      r0_vs       <= 1'b0;
      r0_grow     <= '0;
      r0_gcol     <= '0;
      r1_in_win   <= 1'b0;
      r1_video    <= 1'b0;
      r1_hs       <= 1'b0;
      r1_vs       <= 1'b0;
      r1_gcol     <= '0;
      r1_attr     <= '0;
      r_rgb       <= '0;
      r_hs_out    <= 1'b0;
      r_vs_out    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r0_in_win <= w_in_win;
      r0_video  <= video_on;
      r0_hs     <= hsync_in;
      r0_vs     <= vsync_in;
      r0_grow   <= 4'(w_dy[9:0] >> SCALE_LOG2);
      r0_gcol   <= 3'(w_dx[9:0] >> SCALE_LOG2);

      r1_in_win <= r0_in_win;
      r1_video  <= r0_video;
      r1_hs     <= r0_hs;
      r1_vs     <= r0_vs;
      r1_gcol   <= r0_gcol;
      r1_attr   <= w_ram_rdata[ATTR_W-1:0];

      r_hs_out  <= r1_hs;
      r_vs_out  <= r1_vs;
      if (!r1_video)
        r_rgb <= '0;
      else if (r1_in_win && w_bit && !(r1_attr[ATTR_BLINK] && w_blink))
        r_rgb <= r1_attr[ATTR_FGSEL] ? FG1 : FG0;
      else
        r_rgb <= BG;

      if (w_vs_fall) r_frame_cnt <= r_frame_cnt + 5'd1;
    end
  end

  assign rgb       = r_rgb;
  assign hsync_out = r_hs_out;
  assign vsync_out = r_vs_out;
endmodule

// File: tb/tb_text_overlay_engine.sv
// tb/tb_text_overlay_engine.sv - directed self-checking bench for text_overlay_engine
module tb_text_overlay_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  x, y;
  logic        video_on, hsync_in, vsync_in;
  logic        wr_valid, clr_start;
  logic [4:0]  wr_row;
  logic [6:0]  wr_col, wr_char;
  logic [1:0]  wr_attr;

  logic        hs0, vs0, wr_ready0, wr_err0, busy0;
  logic [11:0] rgb0;
  logic [10:0] rom_addr0;
  logic [7:0]  rom_data0;
  logic        hs1, vs1, wr_ready1, wr_err1, busy1;
  logic [11:0] rgb1;
  logic [10:0] rom_addr1;
  logic [7:0]  rom_data1;

  text_overlay_engine dut0 (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync_out(hs0), .vsync_out(vs0),
    .rgb(rgb0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .wr_attr(wr_attr), .wr_err(wr_err0),
    .clr_start(clr_start), .busy(busy0)
  );

  text_overlay_engine #(.SCALE_LOG2(1)) dut1 (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync_out(hs1), .vsync_out(vs1),
    .rgb(rgb1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .wr_attr(wr_attr), .wr_err(wr_err1),
    .clr_start(clr_start), .busy(busy1)
  );

  // Synthetic font: space is blank, other glyph rows are char ^ {row,row}.
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    if (a[10:4] == 7'h20) return 8'h00;
    return {1'b0, a[10:4]} ^ {a[3:0], a[3:0]};
  endfunction

  always @(posedge clk) begin
    rom_data0 <= rom_fn(rom_addr0);
    rom_data1 <= rom_fn(rom_addr1);
  end

  int tests = 0;
  int fails = 0;
  int frames = 0;
  logic [6:0] sh_char [320];
  logic [1:0] sh_attr [320];
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  string qn[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] model(input int px, input int py, input logic vid, input int s);
    int ox, oy, cw, ch, col, row, gr, gc;
    logic [7:0] g;
    logic [6:0] c;
    logic [1:0] a;
    ox = px - 80;
    oy = py - 80;
    cw = 8 << s;
    ch = 16 << s;
    if (!vid) return 12'h000;
    if (ox < 0 || oy < 0 || ox >= 40 * cw || oy >= 8 * ch) return 12'h008;
    col = ox / cw;
    row = oy / ch;
    c = sh_char[row * 40 + col];
    a = sh_attr[row * 40 + col];
    gr = (oy / (1 << s)) % 16;
    gc = (ox / (1 << s)) % 8;
    g = rom_fn({c, 4'(gr)});
    if (g[7 - gc] && !(a[1] && frames[4])) return a[0] ? 12'hF00 : 12'hFFF;
    return 12'h008;
  endfunction

  task automatic pix(input int px, input int py, input logic vid, input logic [11:0] e0, input string nm);
    string s;
    x = 10'(px);
    y = 10'(py);
    video_on = vid;
    @(posedge clk); #1;
    q0.push_back(e0);
    q1.push_back(model(px, py, vid, 1));
    qn.push_back(nm);
    if (q0.size() == 3) begin
      s = qn.pop_front();
      chk({s, "/s0"}, rgb0, q0.pop_front());
      chk({s, "/s1"}, rgb1, q1.pop_front());
    end
  endtask

  task automatic flush();
    repeat (2) pix(0, 0, 1'b0, 12'h000, "flush");
    q0.delete();
    q1.delete();
    qn.delete();
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1, input string nm);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        pix(xx, yy, 1'b1, model(xx, yy, 1'b1, 0), nm);
    flush();
  endtask

  task automatic check_cells(input string nm);
    for (int i = 0; i < 320; i++) begin
      x = 10'(80 + (i % 40) * 8);
      y = 10'(80 + (i / 40) * 16);
      video_on = 1'b1;
      @(posedge clk); #1;
      chk(nm, rom_addr0, {sh_char[i], 4'h0});
    end
  endtask

  task automatic wr(input int row, input int col, input logic [6:0] ch, input logic [1:0] at,
                    input logic exp_err, input string nm);
    int n;
    n = 0;
    wr_row = 5'(row);
    wr_col = 7'(col);
    wr_char = ch;
    wr_attr = at;
    wr_valid = 1'b1;
    while (!wr_ready0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "/ready"}, n < 1000, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk({nm, "/err"}, wr_err0, exp_err);
    if (!exp_err) begin
      sh_char[row * 40 + col] = ch;
      sh_attr[row * 40 + col] = at;
    end
    @(posedge clk); #1;
    chk({nm, "/err_clr"}, wr_err0, 0);
  endtask

  task automatic vs_pulse();
    vsync_in = 1'b0;
    @(posedge clk); #1; chk("vs_dly1", vs0, 1);
    @(posedge clk); #1; chk("vs_dly2", vs0, 1);
    @(posedge clk); #1; chk("vs_dly3", vs0, 0);
    vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1; chk("vs_rise", vs0, 1);
    frames++;
  endtask

  typedef struct {
    int         px;
    int         py;
    logic       vid;
    logic [11:0] exp;
  } vec_t;
  vec_t vt[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, n1, ready_hi;
    vt[0]  = '{81,  80,  1'b1, 12'hFFF};
    vt[1]  = '{80,  80,  1'b1, 12'h008};
    vt[2]  = '{81,  80,  1'b0, 12'h000};
    vt[3]  = '{79,  80,  1'b1, 12'h008};
    vt[4]  = '{81,  79,  1'b1, 12'h008};
    vt[5]  = '{86,  81,  1'b1, 12'hFFF};
    vt[6]  = '{393, 112, 1'b1, 12'hF00};
    vt[7]  = '{392, 112, 1'b1, 12'h008};
    vt[8]  = '{392, 127, 1'b1, 12'hF00};
    vt[9]  = '{399, 207, 1'b1, 12'h008};
    vt[10] = '{400, 112, 1'b1, 12'h008};
    vt[11] = '{81,  208, 1'b1, 12'h008};

    for (int i = 0; i < 320; i++) begin
      sh_char[i] = 7'h20;
      sh_attr[i] = 2'b00;
    end
    reset = 1'b0;
    x = '0; y = '0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    wr_valid = 1'b0; clr_start = 1'b0;
    wr_row = '0; wr_col = '0; wr_char = '0; wr_attr = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb0, 0);
    chk("rst_hs", hs0, 0);
    chk("rst_vs", vs0, 0);
    chk("rst_err", wr_err0, 0);
    chk("rst_ready", wr_ready0, 0);
    chk("rst_busy", busy0, 1);
    chk("rst_s1", {hs1, vs1, wr_ready1, wr_err1, busy1}, 5'b00001);

    reset = 1'b1;
    n = 0;
    while (busy0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_len", n, 320);
    chk("ready_after", wr_ready0, 1);
    chk("busy_s1_after", busy1, 0);

    hsync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1; chk("hs_dly2", hs0, 1);
    @(posedge clk); #1; chk("hs_dly3", hs0, 0);
    hsync_in = 1'b1;

    check_cells("clr_cells");

    wr(0, 0, 7'h53, 2'b00, 1'b0, "wr_S");
    scan(80, 87, 80, 95, "S_glyph");

    wr(2, 39, 7'h41, 2'b01, 1'b0, "wr_A");
    wr(8, 0, 7'h42, 2'b00, 1'b1, "wr_B");
    check_cells("after_B");
    scan(392, 399, 112, 127, "A_glyph");

    for (int i = 0; i < 12; i++)
      pix(vt[i].px, vt[i].py, vt[i].vid, vt[i].exp, $sformatf("vec%0d", i));
    flush();

    wr(1, 0, 7'h53, 2'b10, 1'b0, "wr_blink");
    for (int f = 0; f < 32; f++) begin
      if (f == 0 || f == 16) begin
        pix(81, 96, 1'b1, (f < 16) ? 12'hFFF : 12'h008, "blink_hand");
        flush();
      end
      scan(80, 87, 96, 111, $sformatf("blink_f%0d", f));
      vs_pulse();
    end

    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    wr_row = 5'd3; wr_col = 7'd5; wr_char = 7'h5A; wr_attr = 2'b00;
    wr_valid = 1'b1;
    chk("clr_busy_next", busy0, 1);
    n = 0;
    ready_hi = 0;
    while (busy0 && n < 1000) begin
      if (wr_ready0) ready_hi++;
      n++;
      clr_start = (n == 100);
      @(posedge clk); #1;
    end
    clr_start = 1'b0;
    chk("clr_len", n, 320);
    chk("clr_ready_low", ready_hi, 0);
    chk("clr_ready_end", wr_ready0, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("held_wr_err", wr_err0, 0);
    for (int i = 0; i < 320; i++) begin
      sh_char[i] = 7'h20;
      sh_attr[i] = 2'b00;
    end
    sh_char[3 * 40 + 5] = 7'h5A;
    check_cells("after_clr");

    scan(160, 175, 176, 207, "scale");

    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("midclr_busy", busy0, 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy0, 1);
    chk("midrst_ready", wr_ready0, 0);
    chk("midrst_rgb", rgb0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0; n0 = 0; n1 = 0;
    while ((busy0 || busy1) && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (!busy0 && n0 == 0) n0 = n;
      if (!busy1 && n1 == 0) n1 = n;
    end
    chk("restart_len_s0", n0, 320);
    chk("restart_len_s1", n1, 320);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
